// File: rtl/spi_range_router.sv
// SPI flash read router: snoops the selected host SPI bus, decodes the opcode and
// address, and resolves the address against programmable windows to a flash target.
module spi_range_router #(
  parameter int NUM_RANGES  = 4,
  parameter int NUM_FLASH   = 2,
  parameter int ADDR_W      = 32,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (NUM_FLASH > 2) ? $clog2(NUM_FLASH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        h_clk,
  input  logic                        h_cs_n,
  input  logic                        h_mosi,
  input  logic [NUM_RANGES*ADDR_W-1:0] range_start,
  input  logic [NUM_RANGES*ADDR_W-1:0] range_end,
  input  logic [NUM_RANGES-1:0]       range_enable,
  input  logic [NUM_RANGES*SEL_W-1:0] range_target,
  input  logic [SEL_W-1:0]            default_target,
  output logic [SEL_W-1:0]            flash_select,
  output logic                        select_valid,
  output logic                        decode_done,
  output logic [NUM_RANGES-1:0]       range_hit,
  output logic                        addr4_mode,
  output logic [7:0]                  cmd_opcode,
  output logic [ADDR_W-1:0]           cmd_address,
  output logic [2:0]                  state
);

  if (!((ADDR_W == 24) || (ADDR_W == 32)) || (NUM_RANGES < 1) || (NUM_RANGES > 8) ||
      (NUM_FLASH < 2) || (NUM_FLASH > 8) || (SYNC_STAGES < 2)) begin : g_bad_params
    $error("spi_range_router: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_ROUTE  = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t cur_state;
  state_t next_state;

  assign state = cur_state;

  // ---------------------------------------------------------------------------
  // Host input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   cs_fall;
  logic                   cs_rise;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;   // CS idles high, so leaving reset never fakes a CS fall
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], h_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], h_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], h_mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  // ---------------------------------------------------------------------------
  // Shift register, opcode classification and address assembly
  // ---------------------------------------------------------------------------
  logic [30:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        addr_is_32;
  logic        mode_set_pend;
  logic        mode_clr_pend;
  logic [7:0]  opcode_now;
  logic        is_read3;
  logic        is_read4;
  logic        addr_last;
  logic [31:0] addr_shifted;
  logic [31:0] addr_captured;

  assign opcode_now   = {shift_reg[6:0], mosi_s};
  assign addr_shifted = {shift_reg, mosi_s};
  // A 3-byte address shares the shifter with the opcode bits above it; mask them off.
  assign addr_captured = addr_is_32 ? addr_shifted : {8'h00, addr_shifted[23:0]};
  assign addr_last     = (bit_cnt == (addr_is_32 ? 5'd31 : 5'd23));

  // NOTE: every signal assigned in an always_comb gets a default first, otherwise
  // an unlisted case path would infer a latch.
  always_comb begin
    is_read3 = 1'b0;
    is_read4 = 1'b0;
    case (opcode_now)
      8'h03, 8'h0B, 8'h3B, 8'h6B, 8'hBB, 8'hEB: is_read3 = 1'b1;
      8'h13, 8'h0C, 8'h3C, 8'h6C, 8'hBC, 8'hEC: is_read4 = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window comparison: lowest enabled matching index wins
  // ---------------------------------------------------------------------------
  logic                  route_found;
  logic [NUM_RANGES-1:0] route_hit;
  logic [SEL_W-1:0]      route_target;

  always_comb begin
    route_found  = 1'b0;
    route_hit    = '0;
    route_target = flash_select;  // holds default_target sampled at CS fall
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (!route_found && range_enable[i] &&
          (range_start[i*ADDR_W +: ADDR_W] <= cmd_address) &&
          (cmd_address <= range_end[i*ADDR_W +: ADDR_W])) begin
        route_found  = 1'b1;
        route_hit[i] = 1'b1;
        route_target = range_target[i*SEL_W +: SEL_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= ST_IDLE;
    else     cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE: begin
        if (cs_fall) next_state = ST_OPCODE;
      end
      ST_OPCODE: begin
        if (cs_rise)
          next_state = ST_IDLE;
        else if (sclk_rise && (bit_cnt == 5'd7))
          next_state = (is_read3 || is_read4) ? ST_ADDR : ST_HOLD;
      end
      ST_ADDR: begin
        if (cs_rise)                     next_state = ST_IDLE;
        else if (sclk_rise && addr_last) next_state = ST_ROUTE;
      end
      ST_ROUTE: begin
        next_state = cs_rise ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (cs_rise) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg     <= '0;
      bit_cnt       <= '0;
      addr_is_32    <= 1'b0;
      mode_set_pend <= 1'b0;
      mode_clr_pend <= 1'b0;
      flash_select  <= '0;
      select_valid  <= 1'b0;
      decode_done   <= 1'b0;
      range_hit     <= '0;
      addr4_mode    <= 1'b0;
      cmd_opcode    <= '0;
      cmd_address   <= '0;
    end else begin
      decode_done <= 1'b0;
      case (cur_state)
        ST_IDLE: begin
          if (cs_fall) begin
            bit_cnt       <= '0;
            range_hit     <= '0;
            flash_select  <= default_target;
            select_valid  <= 1'b0;
            mode_set_pend <= 1'b0;
            mode_clr_pend <= 1'b0;
          end
        end
        ST_OPCODE: begin
          if (!cs_rise && sclk_rise) begin
            shift_reg <= {shift_reg[29:0], mosi_s};
            if (bit_cnt == 5'd7) begin
              cmd_opcode    <= opcode_now;
              bit_cnt       <= '0;
              addr_is_32    <= is_read4 | addr4_mode;
              select_valid  <= ~(is_read3 | is_read4);
              mode_set_pend <= (opcode_now == 8'hB7);
              mode_clr_pend <= (opcode_now == 8'hE9);
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ST_ADDR: begin
          if (!cs_rise && sclk_rise) begin
            shift_reg <= {shift_reg[29:0], mosi_s};
            bit_cnt   <= bit_cnt + 5'd1;
            if (addr_last) cmd_address <= addr_captured[ADDR_W-1:0];
          end
        end
        ST_ROUTE: begin
          flash_select <= route_target;
          range_hit    <= route_hit;
          select_valid <= 1'b1;
          decode_done  <= 1'b1;
        end
        ST_HOLD: begin
          // Mode opcodes only take effect once the host closes the transaction.
          if (cs_rise) begin
            if (mode_set_pend)      addr4_mode <= 1'b1;
            else if (mode_clr_pend) addr4_mode <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
